// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: ALU, single-cycle multiply, iterative divider, data-SRAM request
module exe_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         MEM_allow,
  output logic         EX_allow,
  input  logic         ID_to_EX_valid,
  input  logic [160:0] ID_to_EX_bus,
  output logic         EX_to_MEM_valid,
  output logic [74:0]  EX_to_MEM_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [38:0]  EX_to_ID_forward
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic         ex_valid;
  logic [160:0] ex_bus;
  logic         ex_ready_go;

  logic [11:0] alu_op;
  logic [31:0] src1, src2, rkd_value, pc;
  logic [6:0]  md_op;
  logic        res_from_mem, gr_we, mem_we;
  logic [1:0]  st_op;
  logic [3:0]  ld_op;
  logic [4:0]  dest;

  assign {alu_op, src1, src2, rkd_value, md_op, res_from_mem, gr_we, mem_we,
          st_op, ld_op, dest, pc} = ex_bus;

  assign EX_allow = !ex_valid || (ex_ready_go && MEM_allow);

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid <= 1'b0;
    end else if (EX_allow) begin
      ex_valid <= ID_to_EX_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_bus <= '0;
    end else if (ID_to_EX_valid && EX_allow) begin
      ex_bus <= ID_to_EX_bus;
    end
  end

  // ALU: one-hot op select, terms OR-ed together
  logic [31:0] add_res, sub_res, sra_res, alu_result;
  logic        slt_res, sltu_res;
  logic [4:0]  shamt;

  assign shamt    = src2[4:0];
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;
  assign sra_res  = $signed(src1) >>> shamt;

  always_comb begin
    alu_result = ({32{alu_op[0]}}  & add_res)
               | ({32{alu_op[1]}}  & sub_res)
               | ({32{alu_op[2]}}  & {31'd0, slt_res})
               | ({32{alu_op[3]}}  & {31'd0, sltu_res})
               | ({32{alu_op[4]}}  & (src1 & src2))
               | ({32{alu_op[5]}}  & ~(src1 | src2))
               | ({32{alu_op[6]}}  & (src1 | src2))
               | ({32{alu_op[7]}}  & (src1 ^ src2))
               | ({32{alu_op[8]}}  & (src1 << shamt))
               | ({32{alu_op[9]}}  & (src1 >> shamt))
               | ({32{alu_op[10]}} & sra_res)
               | ({32{alu_op[11]}} & src2);
  end

  // Multiply: 33x33 signed product covers both signed and unsigned high halves
  logic               is_mul, mul_signed;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] mul_prod;
  logic [31:0]        mul_result;

  assign is_mul     = |md_op[6:4];
  assign mul_signed = md_op[6] | md_op[5];
  assign mul_a      = {mul_signed & src1[31], src1};
  assign mul_b      = {mul_signed & src2[31], src2};
  assign mul_prod   = mul_a * mul_b;
  assign mul_result = md_op[6] ? mul_prod[31:0] : mul_prod[63:32];

  // Divider: restoring radix-2 on magnitudes, signs fixed up in DONE
  div_state_t  div_state, div_next;
  logic        is_div, div_signed, div_want_rem;
  logic [31:0] div_rem, div_dvd, div_dsr;
  logic [4:0]  div_cnt;
  logic        div_sign_a, div_sign_b;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub, div_q, div_r, div_result;

  assign is_div       = |md_op[3:0];
  assign div_signed   = md_op[3] | md_op[2];
  assign div_want_rem = md_op[2] | md_op[0];
  assign div_shift    = {div_rem, div_dvd[31]};
  assign div_ge       = div_shift >= {1'b0, div_dsr};
  assign div_sub      = div_shift[31:0] - div_dsr;
  assign div_q        = (div_sign_a ^ div_sign_b) ? -div_dvd : div_dvd;
  assign div_r        = div_sign_a ? -div_rem : div_rem;
  assign div_result   = div_want_rem ? div_r : div_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= DIV_IDLE;
    end else begin
      div_state <= div_next;
    end
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (ex_valid && is_div) div_next = DIV_BUSY;
      DIV_BUSY: if (div_cnt == 5'd31) div_next = DIV_DONE;
      DIV_DONE: if (ex_ready_go && MEM_allow) div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_rem    <= '0;
      div_dvd    <= '0;
      div_dsr    <= '0;
      div_cnt    <= '0;
      div_sign_a <= 1'b0;
      div_sign_b <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (ex_valid && is_div) begin
            div_sign_a <= div_signed & src1[31];
            div_sign_b <= div_signed & src2[31];
            div_dvd    <= (div_signed && src1[31]) ? -src1 : src1;
            div_dsr    <= (div_signed && src2[31]) ? -src2 : src2;
            div_rem    <= '0;
            div_cnt    <= '0;
          end
        end
        DIV_BUSY: begin
          div_rem <= div_ge ? div_sub : div_shift[31:0];
          div_dvd <= {div_dvd[30:0], div_ge};
          div_cnt <= div_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  logic [31:0] ex_result;

  assign ex_ready_go = !is_div || (div_state == DIV_DONE);
  assign ex_result   = is_div ? div_result : (is_mul ? mul_result : alu_result);

  // Memory request: store data replicated across lanes, byte enables pick the lane
  logic       st_b, st_h;
  logic [3:0] st_mask;

  assign st_b = st_op[1];
  assign st_h = st_op[0];

  always_comb begin
    st_mask = 4'b1111;
    if (st_b) begin
      st_mask = 4'b0001 << alu_result[1:0];
    end else if (st_h) begin
      st_mask = alu_result[1] ? 4'b1100 : 4'b0011;
    end
  end

  assign data_sram_en    = ex_valid && (res_from_mem || mem_we) && MEM_allow;
  assign data_sram_we    = (data_sram_en && mem_we) ? st_mask : 4'b0000;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = st_b ? {4{rkd_value[7:0]}} :
                           st_h ? {2{rkd_value[15:0]}} : rkd_value;

  assign EX_to_MEM_valid = ex_valid && ex_ready_go;
  assign EX_to_MEM_bus   = {res_from_mem, gr_we, dest, ex_result, pc, ld_op};

  assign EX_to_ID_forward = {gr_we & ex_valid,
                             ex_valid && (res_from_mem || !ex_ready_go),
                             ex_valid ? dest : 5'd0,
                             ex_result};

endmodule
